// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the two-digit decimal entry accumulator.
package dec_entry_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } entry_state_t;

  localparam logic [3:0]  BCD_MAX            = 4'd9;
  localparam int unsigned BCD_W              = 4;
  localparam int unsigned VAL_W              = 7;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 130_000_000;
  // Sized for the default timeout; any smaller override fits as well.
  localparam int unsigned TO_CNT_W           = $clog2(TIMEOUT_CYCLES_DEF + 1);

endpackage

// File: rtl/dec_to_byte_bcd2_to_bin.sv
// Combinational two-digit BCD to 7-bit binary: tens*10 + ones via shifts.
module bcd2_to_bin
  import dec_entry_pkg::*;
(
  input  logic [BCD_W-1:0] i_tens,
  input  logic [BCD_W-1:0] i_ones,
  output logic [VAL_W-1:0] o_val
);

  logic [VAL_W-1:0] w_tens;
  logic [VAL_W-1:0] w_ones;

  assign w_tens = VAL_W'(i_tens);
  assign w_ones = VAL_W'(i_ones);
  assign o_val  = (w_tens << 3) + (w_tens << 1) + w_ones;

endmodule

// File: rtl/dec_to_byte.sv
// Decimal-entry accumulator: collects up to two BCD digits, converts on enter
// with a range check, and discards a stale partial entry after an idle timeout.
module dec_to_byte
  import dec_entry_pkg::*;
#(
  parameter int unsigned MAX_VAL        = 80,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              digit_valid_in,
  input  logic [BCD_W-1:0]  digit_in,
  input  logic              enter_in,
  input  logic              backspace_in,
  input  logic              clear_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid_out,
  output logic              err_out,
  output logic              busy_out,
  output logic [BCD_W-1:0]  tens_out,
  output logic [BCD_W-1:0]  ones_out
);

  entry_state_t        r_state, w_state_nxt;
  logic [BCD_W-1:0]    r_tens, w_tens_nxt;
  logic [BCD_W-1:0]    r_ones, w_ones_nxt;
  logic [BYTE_W-1:0]   r_byte, w_byte_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, w_busy_nxt;
  logic [TO_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [VAL_W-1:0]    w_val;
  logic                w_any_strobe;

  bcd2_to_bin u_bcd2_to_bin (
    .i_tens (r_tens),
    .i_ones (r_ones),
    .o_val  (w_val)
  );

  assign w_any_strobe = clear_in | enter_in | backspace_in | digit_valid_in;

  // Strobe priority: clear > enter > backspace > digit; idle timeout otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_byte_nxt  = r_byte;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = '0;

    if (clear_in) begin
      w_state_nxt = EMPTY;
      w_tens_nxt  = '0;
      w_ones_nxt  = '0;
    end else if (enter_in) begin
      if (r_state == EMPTY) begin
        w_err_nxt = 1'b1;
      end else if (BYTE_W'(w_val) <= BYTE_W'(MAX_VAL)) begin
        w_byte_nxt  = BYTE_W'(w_val);
        w_valid_nxt = 1'b1;
      end else begin
        w_err_nxt = 1'b1;
      end
      w_state_nxt = EMPTY;
      w_tens_nxt  = '0;
      w_ones_nxt  = '0;
    end else if (backspace_in) begin
      case (r_state)
        TWO: begin
          w_state_nxt = ONE;
          w_ones_nxt  = r_tens;
          w_tens_nxt  = '0;
        end
        ONE: begin
          w_state_nxt = EMPTY;
          w_tens_nxt  = '0;
          w_ones_nxt  = '0;
        end
        default: ;
      endcase
    end else if (digit_valid_in) begin
      if (digit_in > BCD_MAX) begin
        w_err_nxt = 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            w_state_nxt = ONE;
            w_tens_nxt  = '0;
            w_ones_nxt  = digit_in;
          end
          ONE: begin
            w_state_nxt = TWO;
            w_tens_nxt  = r_ones;
            w_ones_nxt  = digit_in;
          end
          default: w_err_nxt = 1'b1;
        endcase
      end
    end else if ((r_state != EMPTY) && (TIMEOUT_CYCLES != 0)) begin
      if (r_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
        w_state_nxt = EMPTY;
        w_tens_nxt  = '0;
        w_ones_nxt  = '0;
      end else begin
        w_cnt_nxt = r_cnt + TO_CNT_W'(1);
      end
    end

    w_busy_nxt = (w_state_nxt != EMPTY);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= EMPTY;
      r_tens  <= '0;
      r_ones  <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_byte  <= w_byte_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign byte_out       = r_byte;
  assign byte_valid_out = r_valid;
  assign err_out        = r_err;
  assign busy_out       = r_busy;
  assign tens_out       = r_tens;
  assign ones_out       = r_ones;

endmodule

// File: tb/tb_dec_to_byte.sv
// Self-checking bench: directed test-plan sequences plus random strobes,
// compared every cycle against a digit-queue reference model.
module tb_dec_to_byte;

  localparam int unsigned TO  = 20;
  localparam int unsigned MAX = 80;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       digit_valid_in = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter_in = 1'b0;
  logic       backspace_in = 1'b0;
  logic       clear_in = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       err_out;
  logic       busy_out;
  logic [3:0] tens_out;
  logic [3:0] ones_out;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: digits entered so far, last committed value, idle count.
  int unsigned q[$];
  int unsigned m_byte = 0;
  int unsigned m_valid = 0;
  int unsigned m_err = 0;
  int unsigned m_idle = 0;

  dec_to_byte #(.MAX_VAL(MAX), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .digit_valid_in (digit_valid_in),
    .digit_in       (digit_in),
    .enter_in       (enter_in),
    .backspace_in   (backspace_in),
    .clear_in       (clear_in),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .err_out        (err_out),
    .busy_out       (busy_out),
    .tens_out       (tens_out),
    .ones_out       (ones_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_step(input bit rst, input bit dv, input int unsigned d,
                            input bit en, input bit bs, input bit clr);
    int unsigned val;
    m_valid = 0;
    m_err   = 0;
    if (!rst) begin
      q.delete();
      m_byte = 0;
      m_idle = 0;
    end else if (clr) begin
      q.delete();
    end else if (en) begin
      if (q.size() == 0) m_err = 1;
      else begin
        val = (q.size() == 2) ? q[0] * 10 + q[1] : q[0];
        if (val <= MAX) begin m_byte = val; m_valid = 1; end
        else m_err = 1;
      end
      q.delete();
    end else if (bs) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (dv) begin
      if (d > 9 || q.size() == 2) m_err = 1;
      else q.push_back(d);
    end
    if (rst) begin
      if (clr || en || bs || dv) m_idle = 0;
      else if (q.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin q.delete(); m_idle = 0; end
      end else m_idle = 0;
    end
  endtask

  task automatic compare_all();
    chk("byte_out", 32'(byte_out), m_byte);
    chk("byte_valid", 32'(byte_valid_out), m_valid);
    chk("err", 32'(err_out), m_err);
    chk("busy", 32'(busy_out), (q.size() > 0) ? 1 : 0);
    chk("tens", 32'(tens_out), (q.size() == 2) ? q[0] : 0);
    chk("ones", 32'(ones_out), (q.size() == 2) ? q[1] : (q.size() == 1) ? q[0] : 0);
  endtask

  task automatic tick(input bit rst, input bit dv, input int unsigned d,
                      input bit en, input bit bs, input bit clr);
    @(negedge clk_in);
    rst_n_in       = rst;
    digit_valid_in = dv;
    digit_in       = 4'(d);
    enter_in       = en;
    backspace_in   = bs;
    clear_in       = clr;
    @(posedge clk_in);
    #1;
    model_step(rst, dv, d, en, bs, clr);
    compare_all();
  endtask

  task automatic dig(input int unsigned d); tick(1, 1, d, 0, 0, 0); endtask
  task automatic ent();                    tick(1, 0, 0, 1, 0, 0); endtask
  task automatic bsp();                    tick(1, 0, 0, 0, 1, 0); endtask
  task automatic idle();                   tick(1, 0, 0, 0, 0, 0); endtask

  initial begin
    // Reset with a strobe present; it must be ignored.
    tick(0, 1, 5, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("reset_byte", 32'(byte_out), 0);
    chk("reset_busy", 32'(busy_out), 0);

    dig(4); dig(7);
    chk("tp_tens47", 32'(tens_out), 4);
    chk("tp_ones47", 32'(ones_out), 7);
    ent();
    chk("tp_byte47", 32'(byte_out), 47);
    chk("tp_valid47", 32'(byte_valid_out), 1);
    idle();
    chk("tp_valid_oneshot", 32'(byte_valid_out), 0);

    dig(8); dig(1); ent();
    chk("tp_err81", 32'(err_out), 1);
    chk("tp_keep47", 32'(byte_out), 47);
    dig(8); dig(0); ent();
    chk("tp_byte80", 32'(byte_out), 80);

    dig(5); ent();
    chk("tp_byte5", 32'(byte_out), 5);
    ent();
    chk("tp_err_empty", 32'(err_out), 1);

    dig(1); dig(2); dig(3);
    chk("tp_err_third", 32'(err_out), 1);
    chk("tp_ones_keep", 32'(ones_out), 2);
    bsp();
    chk("tp_bs_ones", 32'(ones_out), 1);
    chk("tp_bs_busy", 32'(busy_out), 1);
    bsp();
    chk("tp_bs_idle", 32'(busy_out), 0);
    bsp();

    dig(3);
    tick(1, 1, 9, 1, 0, 0);
    chk("tp_prio_byte3", 32'(byte_out), 3);
    dig(4);
    tick(1, 0, 0, 1, 0, 1);
    chk("tp_clr_noerr", 32'(err_out), 0);
    chk("tp_clr_busy", 32'(busy_out), 0);
    tick(1, 1, 12, 0, 1, 0);            // losing illegal digit: backspace in EMPTY, no error
    dig(12);
    chk("tp_illegal", 32'(err_out), 1);

    dig(6);
    for (int i = 0; i < int'(TO) - 1; i++) idle();
    chk("tp_to_before", 32'(busy_out), 1);
    idle();
    chk("tp_to_after", 32'(busy_out), 0);
    chk("tp_to_noerr", 32'(err_out), 0);

    dig(2); dig(7);
    tick(0, 0, 0, 0, 0, 0);
    chk("tp_rst_busy", 32'(busy_out), 0);
    chk("tp_rst_byte", 32'(byte_out), 0);

    // Random strobes, with occasional long idle gaps to reach the timeout.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        for (int k = 0; k < int'($urandom_range(15, 25)); k++) idle();
      end else if (r < 3) begin
        tick(0, $urandom_range(0, 1), 0, 0, 0, 0);
      end else begin
        tick(1, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 85 ? $urandom_range(0, 9) : $urandom_range(10, 15),
             $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dec_to_byte.md
# dec_to_byte

Sequential decimal-entry accumulator: collects up to two BCD digit strobes from the keypad/button debouncer, echoes the partial entry for seven-segment display, and on an enter strobe converts the entry to a binary byte with a range check. It is the inverse of the binary-to-two-digit decimal display path. Committed values feed the move/position logic as board indices 0–80.

## Interface
- MAX_VAL, 80: largest accepted value, inclusive; larger values raise err_out.
- TIMEOUT_CYCLES, 130_000_000: idle cycles after which a partial entry is discarded (2 s at 65 MHz); 0 disables the timeout.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_n_in  input  1  synchronous, active-low reset.
- digit_valid_in  input  1  one-cycle strobe; digit_in is valid.
- digit_in  input  4  BCD digit; 10–15 are illegal.
- enter_in  input  1  one-cycle commit strobe.
- backspace_in  input  1  one-cycle strobe; removes the last digit.
- clear_in  input  1  one-cycle strobe; aborts the entry.
- byte_out  output  8  last committed value; held until the next commit.
- byte_valid_out  output  1  one-cycle pulse; byte_out has been updated.
- err_out  output  1  one-cycle pulse on any rejected event.
- busy_out  output  1  high while the state is not EMPTY.
- tens_out, ones_out  output  4 each  current entry digits for display.

## Operation
- States: EMPTY, ONE (one digit held), TWO (two digits held).
- Digit strobe:
  - EMPTY→ONE: ones=d, tens=0.
  - ONE→TWO: tens=ones, ones=d.
  - In TWO: err_out pulses, the digit is dropped, state is unchanged.
  - digit_in > 9 in any state: err_out pulses, nothing else changes.
- Backspace:
  - TWO→ONE: ones=tens, tens=0.
  - ONE→EMPTY: digits cleared.
  - In EMPTY: no-op, no error.
- Clear: any state→EMPTY, digits cleared, no pulse.
- Enter:
  - In EMPTY: err_out pulses.
  - Otherwise compute val = tens*10 + ones as (tens<<3)+(tens<<1)+ones, 7 bits wide, zero-extended to 8.
  - If val ≤ MAX_VAL: byte_out=val and byte_valid_out pulses.
  - Else: err_out pulses and byte_out is unchanged.
  - In both cases the state goes to EMPTY and digits clear.
- Simultaneous strobes in one cycle: priority is clear > enter > backspace > digit. Only the winner acts. A losing illegal digit does not raise err_out.
- Timeout:
  - The counter resets on every strobe.
  - It counts while busy_out is high.
  - At TIMEOUT_CYCLES it returns to EMPTY silently.
- byte_valid_out and err_out are never high in the same cycle.

## Timing
- All outputs are registered.
- byte_valid_out, err_out, byte_out, tens_out, ones_out and busy_out all reflect a strobe in cycle N at cycle N+1.
- Reset values: byte_out=0, byte_valid_out=0, err_out=0, busy_out=0, tens_out=0, ones_out=0, state=EMPTY, timeout counter=0.
- Reset mid-entry discards the entry. Strobes asserted in the reset cycle are ignored.
- Back-to-back strobes on consecutive cycles are all accepted; there is no dead cycle after enter.
- Inputs are already single-cycle pulses from the debouncer; there is no internal edge detection.

## Structure
- Package dec_entry_pkg holds:
  - the state enum entry_state_t {EMPTY, ONE, TWO};
  - localparam BCD_MAX = 4'd9;
  - the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- Sub-module bcd2_to_bin: combinational, tens/ones → 7-bit value. The top-level FSM registers its result.

## Test plan
- Digits 4, 7 then enter → tens_out=4/ones_out=7 after the second digit; byte_out=47 with a one-cycle byte_valid_out one cycle after enter; busy_out falls.
- Digits 8, 1, enter → err_out pulse, byte_out keeps its prior value (47). Digits 8, 0, enter → byte_out=80 valid.
- Digit 5, enter → byte_out=5. Enter alone from EMPTY → err_out only.
- Digits 1, 2, 3 → err_out on the third digit, display stays 1/2. Backspace → display 0/1, busy_out high. Backspace → busy_out low.
- Same-cycle enter+digit 9 while holding 3 → byte_out=3 and the 9 is ignored. Same-cycle clear+enter → EMPTY with no pulses. digit_in=12 → err_out, no state change.
- With TIMEOUT_CYCLES=20: digit 6, then wait 20 cycles → busy_out drops, no pulses. rst_n_in low mid-entry → all outputs zero on the next cycle.
